mesh_term_harness: RTL and testbench

Synthesizable, parametrised terminal-side harness for the mesh router: it sits between the mesh's terminal ports and the stimulus/checking logic and plays the role of all `TERMS` endpoints at once. Each terminal gets an injection FIFO that the mesh drains through `popin`. A round-robin ejection arbiter pops delivered packets and forwards them to the checker. A run-control FSM with packet counters and an inactivity watchdog replaces the fixed simulation-time limit with a deterministic done/timeout decision.

---
 rtl/mesh_term_harness.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_mesh_term_harness.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_term_harness.sv
// Terminal-side harness for the mesh router: per-terminal injection FIFOs,
// a round-robin ejection arbiter and a run-control FSM with packet counters
// and an inactivity watchdog that decides done/timeout deterministically.
module mesh_term_harness #(
    parameter int TERMS      = 16,
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int TIMEOUT    = 10000,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CNT_W-1:0]           expected_cnt,
    input  logic                       load_valid,
    input  logic [$clog2(TERMS)-1:0]   load_term,
    input  logic [pckg_sz-1:0]         load_data,
    output logic                       load_ready,
    output logic [TERMS-1:0]           pndng_i_in,
    output logic [TERMS*pckg_sz-1:0]   data_out_i_in,
    input  logic [TERMS-1:0]           popin,
    input  logic [TERMS-1:0]           pndng,
    input  logic [TERMS*pckg_sz-1:0]   data_out,
    output logic [TERMS-1:0]           pop,
    output logic                       rx_valid,
    output logic [$clog2(TERMS)-1:0]   rx_term,
    output logic [pckg_sz-1:0]         rx_data,
    output logic [CNT_W-1:0]           sent_cnt,
    output logic [CNT_W-1:0]           rcvd_cnt,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout
);

    localparam int TW = $clog2(TERMS);
    localparam int PW = $clog2(fifo_depth);
    localparam int FW = PW + 1;
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Injection FIFO storage and bookkeeping
    logic [pckg_sz-1:0] mem_q   [TERMS][fifo_depth];
    logic [PW-1:0]      rdPtr_q [TERMS];
    logic [PW-1:0]      rdPtr_d [TERMS];
    logic [PW-1:0]      wrPtr_q [TERMS];
    logic [PW-1:0]      wrPtr_d [TERMS];
    logic [FW-1:0]      count_q [TERMS];
    logic [FW-1:0]      count_d [TERMS];
    logic [TERMS-1:0]   full;
    logic [TERMS-1:0]   push;
    logic [TERMS-1:0]   popEff;

    // Ejection side
    logic [pckg_sz-1:0] meshPkt [TERMS];
    logic               grantValid;
    logic [TW-1:0]      grantIdx;
    logic [TW-1:0]      candIdx;
    logic [TERMS-1:0]   pop_q, pop_d;
    logic               rxValid_q, rxValid_d;
    logic [TW-1:0]      rxTerm_q, rxTerm_d;
    logic [pckg_sz-1:0] rxData_q, rxData_d;
    logic [TW-1:0]      lastGrant_q, lastGrant_d;

    // Run control
    logic [CNT_W-1:0]   sentCnt_q, sentCnt_d;
    logic [CNT_W-1:0]   rcvdCnt_q, rcvdCnt_d;
    logic [CNT_W-1:0]   expected_q, expected_d;
    logic [WW-1:0]      wd_q, wd_d;
    logic               doneFlag_q, doneFlag_d;
    logic               timeoutFlag_q, timeoutFlag_d;
    logic [TW:0]        sendCount;
    logic [CNT_W:0]     sentSum;
    logic               rcvdHit;
    logic               anyEvent;
    logic               wdExpired;
    logic               enterRun;

    // FIFO status, load acceptance, effective pops and pointer/count updates
    always_comb begin
        load_ready = 1'b0;
        for (int k = 0; k < TERMS; k++) begin
            full[k] = (count_q[k] == FW'(fifo_depth));
        end
        if (int'(load_term) < TERMS) begin
            load_ready = !full[load_term];
        end
        for (int k = 0; k < TERMS; k++) begin
            push[k]       = load_valid && load_ready && (load_term == TW'(k));
            popEff[k]     = popin[k] && (count_q[k] != '0);
            rdPtr_d[k]    = popEff[k] ? rdPtr_q[k] + PW'(1) : rdPtr_q[k];
            wrPtr_d[k]    = push[k]   ? wrPtr_q[k] + PW'(1) : wrPtr_q[k];
            count_d[k]    = count_q[k];
            if (push[k] && !popEff[k]) begin
                count_d[k] = count_q[k] + FW'(1);
            end else if (!push[k] && popEff[k]) begin
                count_d[k] = count_q[k] - FW'(1);
            end
            pndng_i_in[k] = (count_q[k] != '0);
            data_out_i_in[k*pckg_sz +: pckg_sz] = mem_q[k][rdPtr_q[k]];
        end
    end

    // FIFO payload storage; contents are don't-care until written so no reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < TERMS; k++) begin
            if (push[k]) begin
                mem_q[k][wrPtr_q[k]] <= load_data;
            end
        end
    end

    // FIFO pointers and fill levels; reset empties every FIFO
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < TERMS; k++) begin
                rdPtr_q[k] <= '0;
                wrPtr_q[k] <= '0;
                count_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TERMS; k++) begin
                rdPtr_q[k] <= rdPtr_d[k];
                wrPtr_q[k] <= wrPtr_d[k];
                count_q[k] <= count_d[k];
            end
        end
    end

    // Unpack the mesh output bus into per-terminal packets
    always_comb begin
        for (int k = 0; k < TERMS; k++) begin
            meshPkt[k] = data_out[k*pckg_sz +: pckg_sz];
        end
    end

    // Round-robin ejection arbiter; terminals popped last cycle are skipped
    // because the mesh has not yet had a chance to lower pndng, and grants
    // stop once the target count is met so rcvd_cnt never overshoots.
    always_comb begin
        grantValid  = 1'b0;
        grantIdx    = '0;
        candIdx     = '0;
        pop_d       = '0;
        rxValid_d   = 1'b0;
        rxTerm_d    = rxTerm_q;
        rxData_d    = rxData_q;
        lastGrant_d = lastGrant_q;
        if (state_q == RUN && !rcvdHit) begin
            for (int i = 1; i <= TERMS; i++) begin
                candIdx = TW'((int'(lastGrant_q) + i) % TERMS);
                if (!grantValid && pndng[candIdx] && !pop_q[candIdx]) begin
                    grantValid = 1'b1;
                    grantIdx   = candIdx;
                end
            end
        end
        if (grantValid) begin
            pop_d[grantIdx] = 1'b1;
            rxValid_d       = 1'b1;
            rxTerm_d        = grantIdx;
            rxData_d        = meshPkt[grantIdx];
            lastGrant_d     = grantIdx;
        end
    end

    // Ejection registers: pop and the received packet are valid for one cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            pop_q       <= '0;
            rxValid_q   <= 1'b0;
            rxTerm_q    <= '0;
            rxData_q    <= '0;
            lastGrant_q <= TW'(TERMS - 1);
        end else begin
            pop_q       <= pop_d;
            rxValid_q   <= rxValid_d;
            rxTerm_q    <= rxTerm_d;
            rxData_q    <= rxData_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    // Event detection and watchdog expiry for the current cycle
    always_comb begin
        sendCount = '0;
        for (int k = 0; k < TERMS; k++) begin
            sendCount = sendCount + (TW+1)'(popEff[k]);
        end
        sentSum   = {1'b0, sentCnt_q} + (CNT_W+1)'(sendCount);
        rcvdHit   = (rcvdCnt_q == expected_q);
        anyEvent  = (sendCount != '0) || grantValid;
        wdExpired = (wd_q == WW'(TIMEOUT - 1)) && !anyEvent;
        enterRun  = start && (state_q != RUN);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; completion is checked ahead of the watchdog
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (rcvdHit || wdExpired) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Counters, watchdog and result flags; saturating counters, cleared on run entry
    always_comb begin
        sentCnt_d     = sentCnt_q;
        rcvdCnt_d     = rcvdCnt_q;
        expected_d    = expected_q;
        wd_d          = wd_q;
        doneFlag_d    = doneFlag_q;
        timeoutFlag_d = timeoutFlag_q;
        if (enterRun) begin
            sentCnt_d     = '0;
            rcvdCnt_d     = '0;
            expected_d    = expected_cnt;
            wd_d          = '0;
            doneFlag_d    = 1'b0;
            timeoutFlag_d = 1'b0;
        end else if (state_q == RUN) begin
            if (sendCount != '0) begin
                sentCnt_d = sentSum[CNT_W] ? '1 : sentSum[CNT_W-1:0];
            end
            if (grantValid && !(&rcvdCnt_q)) begin
                rcvdCnt_d = rcvdCnt_q + CNT_W'(1);
            end
            wd_d = anyEvent ? '0 : wd_q + WW'(1);
            if (rcvdHit) begin
                doneFlag_d = 1'b1;
            end else if (wdExpired) begin
                timeoutFlag_d = 1'b1;
            end
        end
    end

    // Run-control registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            sentCnt_q     <= '0;
            rcvdCnt_q     <= '0;
            expected_q    <= '0;
            wd_q          <= '0;
            doneFlag_q    <= 1'b0;
            timeoutFlag_q <= 1'b0;
        end else begin
            sentCnt_q     <= sentCnt_d;
            rcvdCnt_q     <= rcvdCnt_d;
            expected_q    <= expected_d;
            wd_q          <= wd_d;
            doneFlag_q    <= doneFlag_d;
            timeoutFlag_q <= timeoutFlag_d;
        end
    end

    // Output decode from state and registered datapath
    always_comb begin
        busy     = (state_q == RUN);
        done     = doneFlag_q;
        timeout  = timeoutFlag_q;
        pop      = pop_q;
        rx_valid = rxValid_q;
        rx_term  = rxTerm_q;
        rx_data  = rxData_q;
        sent_cnt = sentCnt_q;
        rcvd_cnt = rcvdCnt_q;
    end

endmodule

// File: tb/tb_mesh_term_harness.sv
// Self-checking bench for mesh_term_harness: reset values, injection FIFO
// vector table, ejection ordering with a receive scoreboard, watchdog timing,
// pop spacing on a held pndng and reset in the middle of a run.
module tb_mesh_term_harness;

    localparam int TERMS = 16;
    localparam int PSZ   = 40;
    localparam int DEPTH = 4;
    localparam int TMO   = 20;
    localparam int CW    = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [CW-1:0]        expected_cnt;
    logic                 load_valid;
    logic [3:0]           load_term;
    logic [PSZ-1:0]       load_data;
    logic                 load_ready;
    logic [TERMS-1:0]     pndng_i_in;
    logic [TERMS*PSZ-1:0] data_out_i_in;
    logic [TERMS-1:0]     popin;
    logic [TERMS-1:0]     pndng;
    logic [TERMS*PSZ-1:0] data_out;
    logic [TERMS-1:0]     pop;
    logic                 rx_valid;
    logic [3:0]           rx_term;
    logic [PSZ-1:0]       rx_data;
    logic [CW-1:0]        sent_cnt;
    logic [CW-1:0]        rcvd_cnt;
    logic                 busy;
    logic                 done;
    logic                 timeout;

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        logic             ldValid;
        logic [3:0]       ldTerm;
        logic [PSZ-1:0]   ldData;
        logic [TERMS-1:0] popinV;
        logic             expReady;
        logic [TERMS-1:0] expPndng;
        logic             chkHead;
        logic [PSZ-1:0]   expHead;
    } vec_t;

    typedef struct {
        logic [3:0]     term;
        logic [PSZ-1:0] data;
    } rx_exp_t;

    vec_t    vecs[14];
    rx_exp_t sbQ[$];

    mesh_term_harness #(
        .TERMS(TERMS), .pckg_sz(PSZ), .fifo_depth(DEPTH), .TIMEOUT(TMO), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .expected_cnt(expected_cnt),
        .load_valid(load_valid), .load_term(load_term), .load_data(load_data),
        .load_ready(load_ready), .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in),
        .popin(popin), .pndng(pndng), .data_out(data_out), .pop(pop),
        .rx_valid(rx_valid), .rx_term(rx_term), .rx_data(rx_data),
        .sent_cnt(sent_cnt), .rcvd_cnt(rcvd_cnt), .busy(busy), .done(done),
        .timeout(timeout)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit: got stalled run, expected completion");
        $fatal(1, "[TB] time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        load_valid = v.ldValid;
        load_term  = v.ldTerm;
        load_data  = v.ldData;
        popin      = v.popinV;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pndng_i_in"}, 64'(pndng_i_in), 64'h0);
        checkOutput({tag, "_pop"},        64'(pop),        64'h0);
        checkOutput({tag, "_rx_valid"},   64'(rx_valid),   64'h0);
        checkOutput({tag, "_rx_term"},    64'(rx_term),    64'h0);
        checkOutput({tag, "_rx_data"},    64'(rx_data),    64'h0);
        checkOutput({tag, "_sent_cnt"},   64'(sent_cnt),   64'h0);
        checkOutput({tag, "_rcvd_cnt"},   64'(rcvd_cnt),   64'h0);
        checkOutput({tag, "_busy"},       64'(busy),       64'h0);
        checkOutput({tag, "_done"},       64'(done),       64'h0);
        checkOutput({tag, "_timeout"},    64'(timeout),    64'h0);
        checkOutput({tag, "_load_ready"}, 64'(load_ready), 64'h1);
    endtask

    function automatic logic [PSZ-1:0] pktFor(input int k);
        return {8'hD0 + 8'(k), 32'hCAFE_0000 + 32'(k)};
    endfunction

    task automatic quietInputs();
        start      = 1'b0;
        load_valid = 1'b0;
        load_term  = '0;
        load_data  = '0;
        popin      = '0;
        pndng      = '0;
    endtask

    initial begin
        int      doneCyc;
        int      lastPopCyc;
        int      toCyc;
        int      nRx;
        rx_exp_t e;
        logic [TERMS-1:0] expPop;

        reset        = 1'b0;
        expected_cnt = '0;
        data_out     = '0;
        quietInputs();

        // Injection FIFO vectors: loads and pops on terminal 3 (depth 4)
        vecs[0]  = '{1'b1, 4'd3, 40'hA0_0000_0001, 16'h0000, 1'b1, 16'h0008, 1'b1, 40'hA0_0000_0001};
        vecs[1]  = '{1'b1, 4'd3, 40'hB0_0000_0002, 16'h0000, 1'b1, 16'h0008, 1'b1, 40'hA0_0000_0001};
        vecs[2]  = '{1'b1, 4'd3, 40'hC0_0000_0003, 16'h0000, 1'b1, 16'h0008, 1'b1, 40'hA0_0000_0001};
        vecs[3]  = '{1'b1, 4'd3, 40'hD0_0000_0004, 16'h0000, 1'b1, 16'h0008, 1'b1, 40'hA0_0000_0001};
        vecs[4]  = '{1'b1, 4'd3, 40'hE0_0000_0005, 16'h0000, 1'b0, 16'h0008, 1'b1, 40'hA0_0000_0001};
        vecs[5]  = '{1'b0, 4'd0, 40'h0,            16'h0000, 1'b1, 16'h0008, 1'b1, 40'hA0_0000_0001};
        vecs[6]  = '{1'b1, 4'd3, 40'hE0_0000_0005, 16'h0008, 1'b0, 16'h0008, 1'b1, 40'hB0_0000_0002};
        vecs[7]  = '{1'b0, 4'd3, 40'h0,            16'h0008, 1'b1, 16'h0008, 1'b1, 40'hC0_0000_0003};
        vecs[8]  = '{1'b0, 4'd3, 40'h0,            16'h0008, 1'b1, 16'h0008, 1'b1, 40'hD0_0000_0004};
        vecs[9]  = '{1'b0, 4'd3, 40'h0,            16'h0008, 1'b1, 16'h0000, 1'b0, 40'h0};
        vecs[10] = '{1'b1, 4'd3, 40'hF0_0000_0006, 16'h0008, 1'b1, 16'h0008, 1'b1, 40'hF0_0000_0006};
        vecs[11] = '{1'b1, 4'd3, 40'h10_0000_0007, 16'h0008, 1'b1, 16'h0008, 1'b1, 40'h10_0000_0007};
        vecs[12] = '{1'b1, 4'd0, 40'h20_0000_0008, 16'h0008, 1'b1, 16'h0001, 1'b0, 40'h0};
        vecs[13] = '{1'b0, 4'd0, 40'h0,            16'h0001, 1'b1, 16'h0000, 1'b0, 40'h0};

        // Reset held with every input toggling
        for (int i = 0; i < 6; i++) begin
            start        = 1'($urandom);
            load_valid   = 1'($urandom);
            load_term    = 4'($urandom);
            load_data    = {8'($urandom), $urandom};
            popin        = 16'($urandom);
            pndng        = 16'($urandom);
            expected_cnt = 16'($urandom);
            for (int w = 0; w < TERMS; w++) begin
                data_out[w*PSZ +: PSZ] = {8'($urandom), $urandom};
            end
            tick();
            checkResetState("reset_hold");
        end
        reset    = 1'b1;
        data_out = '0;
        quietInputs();
        tick();
        checkResetState("after_reset");

        // Injection FIFO table
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("fifo_v%0d_load_ready", i), 64'(load_ready), 64'(vecs[i].expReady));
            tick();
            checkOutput($sformatf("fifo_v%0d_pndng_i_in", i), 64'(pndng_i_in), 64'(vecs[i].expPndng));
            if (vecs[i].chkHead) begin
                checkOutput($sformatf("fifo_v%0d_head3", i), 64'(data_out_i_in[3*PSZ +: PSZ]), 64'(vecs[i].expHead));
            end
        end
        quietInputs();
        tick();
        checkOutput("idle_popin_not_counted", 64'(sent_cnt), 64'h0);

        // Ejection round-robin: pndng held on 2, 5, 15, expected_cnt = 3
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int w = 0; w < TERMS; w++) begin
            data_out[w*PSZ +: PSZ] = pktFor(w);
        end
        sbQ.push_back('{4'd2,  pktFor(2)});
        sbQ.push_back('{4'd5,  pktFor(5)});
        sbQ.push_back('{4'd15, pktFor(15)});
        expected_cnt = 16'd3;
        pndng        = 16'h8024;
        start        = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("eject_busy_after_start", 64'(busy), 64'h1);
        doneCyc    = -1;
        lastPopCyc = -10;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checkOutput($sformatf("eject_c%0d_pop_matches_rx_valid", i), 64'(|pop), 64'(rx_valid));
            if (rx_valid) begin
                if (sbQ.size() == 0) begin
                    checkOutput($sformatf("eject_c%0d_extra_rx_term", i), 64'(rx_term), 64'hFF);
                end else begin
                    e      = sbQ.pop_front();
                    expPop = 16'h1 << e.term;
                    checkOutput($sformatf("eject_c%0d_rx_term", i), 64'(rx_term), 64'(e.term));
                    checkOutput($sformatf("eject_c%0d_rx_data", i), 64'(rx_data), 64'(e.data));
                    checkOutput($sformatf("eject_c%0d_pop", i),     64'(pop),     64'(expPop));
                    if (sbQ.size() == 0) lastPopCyc = i;
                end
            end
            if (done && doneCyc < 0) doneCyc = i;
        end
        checkOutput("eject_scoreboard_drained", 64'(sbQ.size()), 64'h0);
        checkOutput("eject_third_pop_cycle", 64'(lastPopCyc), 64'd3);
        checkOutput("eject_done_one_after_last_pop", 64'(doneCyc), 64'(lastPopCyc + 1));
        checkOutput("eject_rcvd_cnt", 64'(rcvd_cnt), 64'd3);
        checkOutput("eject_timeout_low", 64'(timeout), 64'h0);
        checkOutput("eject_busy_low", 64'(busy), 64'h0);

        // Watchdog with no traffic: timeout 20 cycles after busy rises
        pndng        = '0;
        expected_cnt = 16'd5;
        start        = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("to_busy_after_start", 64'(busy), 64'h1);
        checkOutput("to_flags_cleared", 64'({done, timeout}), 64'h0);
        toCyc = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (timeout) begin
                toCyc = i;
                break;
            end
        end
        checkOutput("to_cycles_after_busy", 64'(toCyc), 64'd20);
        checkOutput("to_done_low", 64'(done), 64'h0);
        checkOutput("to_busy_low", 64'(busy), 64'h0);

        // Watchdog restarted by a counted send part-way through the run
        load_valid = 1'b1;
        load_term  = 4'd1;
        load_data  = 40'h55_0000_0011;
        tick();
        load_valid = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        toCyc = -1;
        for (int i = 1; i <= 60; i++) begin
            if (i == 10) popin = 16'h0002;
            tick();
            popin = '0;
            if (timeout) begin
                toCyc = i;
                break;
            end
        end
        checkOutput("wd_clear_timeout_cycle", 64'(toCyc), 64'd30);
        checkOutput("wd_clear_sent_cnt", 64'(sent_cnt), 64'd1);
        checkOutput("wd_clear_rcvd_cnt", 64'(rcvd_cnt), 64'd0);

        // pndng[7] held high: pop[7] must alternate
        pndng        = 16'h0080;
        expected_cnt = 16'd100;
        start        = 1'b1;
        tick();
        start = 1'b0;
        nRx   = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            expPop = (i % 2 == 1) ? 16'h0080 : 16'h0000;
            checkOutput($sformatf("hold7_c%0d_pop", i), 64'(pop), 64'(expPop));
            if (rx_valid) begin
                nRx++;
                checkOutput($sformatf("hold7_c%0d_rx_data", i), 64'(rx_data), 64'(pktFor(7)));
            end
        end
        checkOutput("hold7_rx_count", 64'(nRx), 64'd5);
        checkOutput("hold7_rcvd_cnt", 64'(rcvd_cnt), 64'd5);

        // Reset in the middle of a run with two packets queued
        pndng      = '0;
        load_valid = 1'b1;
        load_term  = 4'd4;
        load_data  = 40'h44_0000_0001;
        tick();
        load_data  = 40'h44_0000_0002;
        tick();
        load_valid = 1'b0;
        checkOutput("midrst_queued", 64'(pndng_i_in), 64'h0010);
        checkOutput("midrst_busy_before", 64'(busy), 64'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("midrst_busy", 64'(busy), 64'h0);
        checkOutput("midrst_pndng_i_in", 64'(pndng_i_in), 64'h0);
        checkOutput("midrst_sent_cnt", 64'(sent_cnt), 64'h0);
        checkOutput("midrst_rcvd_cnt", 64'(rcvd_cnt), 64'h0);
        checkOutput("midrst_pop", 64'(pop), 64'h0);
        tick();
        checkOutput("midrst_still_idle", 64'({busy, done, timeout}), 64'h0);
        checkOutput("midrst_still_empty", 64'(pndng_i_in), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
